pipeline_stall_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the

---
 rtl/pipeline_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Stall/flush sequencer for a 5-stage MIPS pipeline. Merges the
//               load-use hazard flag, the ID-stage branch decision and the
//               data-memory wait handshake into per-stage write enables,
//               IF/ID flush, ID/EX bubble and the data-memory request line.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
  output logic             mem_req_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0]  C_TIMEOUT  = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              freeze;
  logic              in_err;

  // Freeze condition and memory request derived from the handshake state.
  always_comb begin
    freeze    = 1'b0;
    mem_req_o = 1'b0;
    in_err    = 1'b0;
    case (state_q)
      S_RUN: begin
        mem_req_o = mem_access_i & ~rst_i;
        freeze    = mem_access_i & ~mem_ack_i;
      end
      S_WAIT: begin
        mem_req_o = ~rst_i;
        freeze    = ~mem_ack_i;
      end
      S_ERR: begin
        in_err = 1'b1;
      end
      default: begin
        in_err = 1'b1;
      end
    endcase
  end

  // Per-stage enables: reset/error > freeze > load-use > branch > normal.
  always_comb begin
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_mem_write_o = 1'b0;
    mem_wb_write_o = 1'b0;
    if (rst_i || in_err || freeze) begin
      // whole pipe holds; defaults already zero
    end else if (load_use_i) begin
      id_ex_bubble_o = 1'b1;
      ex_mem_write_o = 1'b1;
      mem_wb_write_o = 1'b1;
    end else begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = branch_taken_i;
      ex_mem_write_o = 1'b1;
      mem_wb_write_o = 1'b1;
    end
  end

  // Next-state for the memory-wait sequencer and the stall statistic.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_RUN: begin
        if (freeze) begin
          state_d    = S_WAIT;
          wait_cnt_d = TO_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == C_TIMEOUT) begin
          state_d = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
    // Saturating count of cycles in which the PC did not advance.
    if (!pc_write_o && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o          = in_err & ~rst_i;
  assign stall_cycles_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Self-checking bench for pipeline_stall_ctrl: vector table,
//               hand-written multi-cycle sequences and randomized traffic
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             load_use_i = 1'b0;
  logic             branch_taken_i = 1'b0;
  logic             mem_access_i = 1'b0;
  logic             mem_ack_i = 1'b0;
  logic             pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o;
  logic             ex_mem_write_o, mem_wb_write_o, mem_req_o, err_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [7:0]       outs;

  int checks = 0;
  int errors = 0;

  // model state: error flag, cycles spent waiting (0 = not waiting), stall count
  bit m_err;
  int m_wait;
  int m_cnt;

  typedef struct {
    logic       lu;
    logic       br;
    logic       acc;
    logic       ack;
    logic [7:0] exp;
    int         cnt;
  } vec_t;

  vec_t vecs[11];

  pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_use_i     (load_use_i),
    .branch_taken_i (branch_taken_i),
    .mem_access_i   (mem_access_i),
    .mem_ack_i      (mem_ack_i),
    .pc_write_o     (pc_write_o),
    .if_id_write_o  (if_id_write_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .ex_mem_write_o (ex_mem_write_o),
    .mem_wb_write_o (mem_wb_write_o),
    .mem_req_o      (mem_req_o),
    .err_o          (err_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // outs = {pc, if_id, flush, bubble, ex_mem, mem_wb, req, err}
  assign outs = {pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
                 ex_mem_write_o, mem_wb_write_o, mem_req_o, err_o};

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s outs got=%b exp=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s stall_cycles got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic lu, input logic br, input logic acc, input logic ack);
    load_use_i     = lu;
    branch_taken_i = br;
    mem_access_i   = acc;
    mem_ack_i      = ack;
  endtask

  // Reset pulse spanning one full clock; outputs must be all zero while asserted.
  task automatic do_reset();
    @(negedge clk_i);
    set_in(0, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    chk8("reset_outs", outs, 8'h00);
    chkn("reset_cnt", int'(stall_cycles_o), 0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    m_err  = 0;
    m_wait = 0;
    m_cnt  = 0;
  endtask

  // Behavioural expectation of the outputs for the current cycle.
  function automatic logic [7:0] model_out(input logic lu, input logic br,
                                           input logic acc, input logic ack);
    bit waiting, hold, req;
    if (m_err) return 8'b0000_0001;
    waiting = (m_wait > 0);
    req     = waiting || acc;
    hold    = req && !ack;
    if (hold)    return {7'b0000_000, 1'b0} | {6'b0, req, 1'b0};
    if (lu)      return {6'b0001_11, req, 1'b0};
    return {2'b11, br, 3'b011, req, 1'b0};
  endfunction

  task automatic model_advance(input logic acc, input logic ack, input logic [7:0] exp);
    if (exp[7] == 1'b0) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
    if (m_err) return;
    if (m_wait > 0) begin
      if (ack)                   m_wait = 0;
      else if (m_wait == TIMEOUT) m_err = 1;
      else                       m_wait++;
    end else if (acc && !ack) begin
      m_wait = 1;
    end
  endtask

  // One clock with given inputs, checked against the model.
  task automatic step_model(input string nm, input logic lu, input logic br,
                            input logic acc, input logic ack);
    logic [7:0] e;
    @(negedge clk_i);
    rst_i = 1'b0;
    set_in(lu, br, acc, ack);
    #1;
    e = model_out(lu, br, acc, ack);
    chk8(nm, outs, e);
    chkn(nm, int'(stall_cycles_o), m_cnt);
    model_advance(acc, ack, e);
  endtask

  initial begin
    // {lu, br, acc, ack, expected outs, expected stall count before this cycle}
    vecs[0]  = '{0, 0, 0, 0, 8'b1100_1100, 0};  // idle
    vecs[1]  = '{1, 0, 0, 0, 8'b0001_1100, 0};  // load-use bubble
    vecs[2]  = '{1, 1, 0, 0, 8'b0001_1100, 1};  // load-use beats branch
    vecs[3]  = '{0, 1, 0, 0, 8'b1110_1100, 2};  // branch flush
    vecs[4]  = '{0, 0, 1, 1, 8'b1100_1110, 2};  // same-cycle ack: no stall
    vecs[5]  = '{0, 0, 1, 0, 8'b0000_0010, 2};  // access without ack freezes
    vecs[6]  = '{0, 1, 0, 0, 8'b0000_0010, 3};  // waiting, branch ignored
    vecs[7]  = '{1, 0, 0, 0, 8'b0000_0010, 4};  // waiting, load-use ignored
    vecs[8]  = '{1, 0, 0, 1, 8'b0001_1110, 5};  // ack: freeze drops, load-use acts
    vecs[9]  = '{0, 0, 0, 0, 8'b1100_1100, 6};
    vecs[10] = '{0, 0, 0, 0, 8'b1100_1100, 6};

    m_err = 0; m_wait = 0; m_cnt = 0;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      set_in(vecs[i].lu, vecs[i].br, vecs[i].acc, vecs[i].ack);
      #1;
      chk8($sformatf("vec%0d", i), outs, vecs[i].exp);
      chkn($sformatf("vec%0d", i), int'(stall_cycles_o), vecs[i].cnt);
    end

    // Ack three cycles after access, branch held during the freeze.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      set_in(0, (i > 0), 1, 0);
      #1;
      chk8($sformatf("memwait_c%0d", i), outs, 8'b0000_0010);
    end
    @(negedge clk_i);
    set_in(0, 1, 1, 1);
    #1;
    chk8("memwait_ack", outs, 8'b1110_1110);
    @(negedge clk_i);
    set_in(0, 0, 0, 0);
    #1;
    chk8("memwait_after", outs, 8'b1100_1100);
    chkn("memwait_cnt", int'(stall_cycles_o), 3);

    // Timeout into the sticky error state, then reset out of it.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      set_in(0, 0, 1, 0);
      #1;
      chk8($sformatf("tmo_c%0d", i), outs, 8'b0000_0010);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      set_in(0, 0, 1, (i == 1));
      #1;
      chk8($sformatf("err_c%0d", i), outs, 8'b0000_0001);
    end
    @(negedge clk_i);
    set_in(0, 0, 0, 0);
    #1;
    chk8("err_sticky", outs, 8'b0000_0001);
    chkn("err_cnt", int'(stall_cycles_o), 8);
    #1 rst_i = 1'b1;
    #1;
    chk8("err_async_rst", outs, 8'h00);
    chkn("err_async_rst", int'(stall_cycles_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk8("err_recovered", outs, 8'b1100_1100);

    // Reset mid-wait drops the request without waiting for a clock edge.
    @(negedge clk_i);
    set_in(0, 0, 1, 0);
    @(negedge clk_i);
    set_in(0, 0, 0, 0);
    #1;
    chk8("wait_req", outs, 8'b0000_0010);
    #1 rst_i = 1'b1;
    #1;
    chk8("wait_async_rst", outs, 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk8("wait_recovered", outs, 8'b1100_1100);

    // Saturation of the stall counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      set_in(1, 0, 0, 0);
    end
    @(negedge clk_i);
    set_in(0, 0, 0, 0);
    #1;
    chkn("saturate", int'(stall_cycles_o), CNT_MAX);
    chk8("saturate_outs", outs, 8'b1100_1100);

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        step_model("rand",
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 2) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
